// File: rtl/iddrx2_align_ctrl.sv
// iddrx2_align_ctrl
//   Word-alignment sequencer for an x2-gearing input DDR cell. During link
//   training it watches the SCLK-domain word {Q3,Q2,Q1,Q0}. It pulses ALIGNWD,
//   one slip per pulse, until PATTERN is seen on MATCH_CNT consecutive cycles,
//   then reports lock. If MAX_SLIPS slips are used up without lock, it reports FAIL.
//
// Ports
//   i_sclk       system clock, the same SCLK as the IDDRX2E
//   i_rst        asynchronous active-high reset
//   i_start      begin or restart alignment (level, sampled on i_sclk)
//   i_q0..i_q3   deserialized bits from the IDDRX2E
//   o_alignwd    one-cycle slip request to IDDRX2E.ALIGNWD
//   o_busy       alignment attempt in progress (SETTLE/CHECK/SLIP)
//   o_locked     pattern aligned
//   o_fail       slips exhausted without lock
//   o_slip_cnt   slips issued in the current attempt
//
// Build option
//   IDDRX2_ALIGN_MONITOR_EN: keep comparing while locked. After ERR_LIMIT
//   consecutive bad words, drop lock and re-settle. SLIP_CNT is kept.
module iddrx2_align_ctrl #(
  parameter logic [3:0]  PATTERN    = 4'b0011,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned MATCH_CNT  = 16,
  parameter int unsigned MAX_SLIPS  = 7,
  parameter int unsigned ERR_LIMIT  = 4
) (
  input  logic       i_sclk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_q0,
  input  logic       i_q1,
  input  logic       i_q2,
  input  logic       i_q3,
  output logic       o_alignwd,
  output logic       o_busy,
  output logic       o_locked,
  output logic       o_fail,
  output logic [2:0] o_slip_cnt
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] MatchLast  = 8'(MATCH_CNT - 1);
  localparam logic [2:0] SlipMax    = 3'(MAX_SLIPS);

  typedef enum logic [2:0] {
    StIdle, StSettle, StCheck, StSlip, StLock, StFailed
  } state_t;

  state_t     r_state;
  logic [7:0] r_settle_cnt;
  logic [7:0] r_run_cnt;
  logic [2:0] r_slip_cnt;
  logic       r_alignwd;
  logic       r_busy;
  logic       r_locked;
  logic       r_fail;

  logic [3:0] w_word;
  logic       w_match;

  assign w_word  = {i_q3, i_q2, i_q1, i_q0};
  // An X on Q makes this compare X, so the if() below takes the mismatch path.
  assign w_match = (w_word == PATTERN);

`ifdef IDDRX2_ALIGN_MONITOR_EN
  localparam logic [3:0] ErrLast = 4'(ERR_LIMIT - 1);
  logic [3:0] r_err_cnt;
`else
  // ERR_LIMIT only matters for the lock monitor. This empty block keeps the
  // parameter referenced in the default build.
  if (ERR_LIMIT == 0) begin : g_err_limit_unused
  end
`endif

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_settle_cnt <= 8'd0;
      r_run_cnt    <= 8'd0;
      r_slip_cnt   <= 3'd0;
      r_alignwd    <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
`ifdef IDDRX2_ALIGN_MONITOR_EN
      r_err_cnt    <= 4'd0;
`endif
    end else begin
      // ALIGNWD is only ever raised on entry to SLIP, so it lasts one cycle.
      r_alignwd <= 1'b0;
      case (r_state)
        StIdle, StFailed: begin
          if (i_start) begin
            r_state      <= StSettle;
            r_settle_cnt <= 8'd0;
            r_slip_cnt   <= 3'd0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        StSettle: begin
          if (r_settle_cnt == SettleLast) begin
            r_state   <= StCheck;
            r_run_cnt <= 8'd0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end
        StCheck: begin
          if (w_match) begin
            if (r_run_cnt == MatchLast) begin
              r_state  <= StLock;
              r_locked <= 1'b1;
              r_busy   <= 1'b0;
`ifdef IDDRX2_ALIGN_MONITOR_EN
              r_err_cnt <= 4'd0;
`endif
            end else begin
              r_run_cnt <= r_run_cnt + 8'd1;
            end
          end else if (r_slip_cnt < SlipMax) begin
            r_state    <= StSlip;
            r_alignwd  <= 1'b1;
            r_slip_cnt <= (r_slip_cnt == 3'd7) ? 3'd7 : r_slip_cnt + 3'd1;
          end else begin
            r_state <= StFailed;
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        StSlip: begin
          r_state      <= StSettle;
          r_settle_cnt <= 8'd0;
        end
        StLock: begin
          if (i_start) begin
            r_state      <= StSettle;
            r_settle_cnt <= 8'd0;
            r_slip_cnt   <= 3'd0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b1;
          end
`ifdef IDDRX2_ALIGN_MONITOR_EN
          else if (w_match) begin
            r_err_cnt <= 4'd0;
          end else if (r_err_cnt == ErrLast) begin
            // Lock lost: re-settle without clearing the slip history.
            r_state      <= StSettle;
            r_settle_cnt <= 8'd0;
            r_err_cnt    <= 4'd0;
            r_locked     <= 1'b0;
            r_busy       <= 1'b1;
          end else begin
            r_err_cnt <= r_err_cnt + 4'd1;
          end
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_alignwd  = r_alignwd;
  assign o_busy     = r_busy;
  assign o_locked   = r_locked;
  assign o_fail     = r_fail;
  assign o_slip_cnt = r_slip_cnt;

endmodule

// File: tb/tb_iddrx2_align_ctrl.sv
// Directed bench for iddrx2_align_ctrl with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// "steps" counts rising edges from the edge that samples START.
module tb_iddrx2_align_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] q;
  logic       alignwd;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [2:0] slip_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int   steps;
  int   pulses;
  int   first_pulse;
  int   last_pulse;
  int   consec_viol;
  logic prev_aw;
  bit   model_en = 1'b0;
  int   model_slips;

  iddrx2_align_ctrl dut (
    .i_sclk     (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_q0       (q[0]),
    .i_q1       (q[1]),
    .i_q2       (q[2]),
    .i_q3       (q[3]),
    .o_alignwd  (alignwd),
    .o_busy     (busy),
    .o_locked   (locked),
    .o_fail     (fail),
    .o_slip_cnt (slip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge. ALIGNWD pulses are tracked here. With model_en set, Q
  // follows the slips like an IDDRX2E whose word is two slips away from PATTERN.
  task automatic step();
    @(posedge clk);
    #1;
    steps++;
    if (alignwd === 1'b1) begin
      pulses++;
      if (pulses == 1) first_pulse = steps;
      last_pulse = steps;
      if (prev_aw === 1'b1) consec_viol++;
      if (model_en) begin
        model_slips++;
        q = (model_slips >= 2) ? 4'b0011 : 4'b1100;
      end
    end
    prev_aw = alignwd;
  endtask

  task automatic begin_run();
    steps       = 0;
    pulses      = 0;
    first_pulse = 0;
    last_pulse  = 0;
    consec_viol = 0;
    prev_aw     = 1'b0;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_done(input int limit);
    while (!(locked === 1'b1 || fail === 1'b1) && steps < limit) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    q     = 4'b0000;
    do_reset();
    check("rst_alignwd", alignwd, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_slip_cnt", slip_cnt, 0);

    // 1: already aligned -> lock on edge 1+8+16 = 25, no slips.
    q = 4'b0011;
    begin_run();
    check("t1_busy_after_start", busy, 1);
    repeat (23) step();
    check("t1_locked_edge24", locked, 0);
    step();
    check("t1_locked_edge25", locked, 1);
    check("t1_busy_at_lock", busy, 0);
    check("t1_slip_cnt", slip_cnt, 0);
    check("t1_pulses", pulses, 0);
    check("t1_fail", fail, 0);

    // 5: START in LOCK retrains; START re-pulsed in CHECK is ignored.
    begin_run();
    check("t5_locked_cleared", locked, 0);
    check("t5_busy_set", busy, 1);
    repeat (11) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    check("t5_locked_edge24", locked, 0);
    step();
    check("t5_locked_edge25", locked, 1);

    // 2: two slips needed. Pulses on edges 10 and 20, lock on edge 45.
    do_reset();
    model_en    = 1'b1;
    model_slips = 0;
    q           = 4'b1001;
    begin_run();
    run_until_done(200);
    model_en = 1'b0;
    check("t2_lock_step", steps, 45);
    check("t2_locked", locked, 1);
    check("t2_pulses", pulses, 2);
    check("t2_first_pulse", first_pulse, 10);
    check("t2_second_pulse", last_pulse, 20);
    check("t2_slip_cnt", slip_cnt, 2);
    check("t2_no_back_to_back", consec_viol, 0);

    // 3: never matches. 7 pulses, then FAILED on edge 80.
    do_reset();
    q = 4'b1111;
    begin_run();
    run_until_done(200);
    check("t3_fail_step", steps, 80);
    check("t3_fail", fail, 1);
    check("t3_busy", busy, 0);
    check("t3_locked", locked, 0);
    check("t3_slip_cnt", slip_cnt, 7);
    check("t3_pulses", pulses, 7);
    check("t3_no_back_to_back", consec_viol, 0);

    // Restart from FAILED clears FAIL and locks normally.
    q = 4'b0011;
    begin_run();
    check("t3_restart_fail_cleared", fail, 0);
    run_until_done(200);
    check("t3_restart_lock_step", steps, 25);

    // 4: X on Q counts as a mismatch. RST during SLIP cuts the pulse asynchronously.
    do_reset();
    q = 4'bxxxx;
    begin_run();
    while (alignwd !== 1'b1 && steps < 50) step();
    check("t4_x_slip_step", steps, 10);
    check("t4_slip_cnt_before_rst", slip_cnt, 1);
    rst = 1'b1;
    #1;
    check("t4_async_alignwd", alignwd, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_slip_cnt", slip_cnt, 0);
    #1;
    rst = 1'b0;
    q   = 4'b0011;
    begin_run();
    run_until_done(200);
    check("t4_restart_lock_step", steps, 25);
    check("t4_restart_slip_cnt", slip_cnt, 0);

`ifdef IDDRX2_ALIGN_MONITOR_EN
    // 6: three bad words and one good word keep lock. Four bad words drop it.
    q = 4'b1111;
    repeat (3) step();
    q = 4'b0011;
    step();
    check("t6_hold_after_3bad_1good", locked, 1);
    q = 4'b1111;
    repeat (3) step();
    check("t6_hold_after_3bad", locked, 1);
    step();
    check("t6_drop_locked", locked, 0);
    check("t6_drop_busy", busy, 1);
    check("t6_drop_slip_kept", slip_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
